// File: rtl/chacha_qr_pkg.sv
// Shared types and constants for the ChaCha quarter-round bus host.
// Byte addressing: [3:2] picks word a/b/c/d, [1:0] picks the byte, little-endian.
package chacha_qr_pkg;

    localparam int NUM_BYTES  = 16;
    localparam int ROUNDS_W   = 5;
    localparam int WORD_SEL_W = 2;
    localparam int BYTE_SEL_W = 2;
    localparam int ADDR_W     = WORD_SEL_W + BYTE_SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ROUND,
        ST_READ,
        ST_FIN
    } state_t;

endpackage

// File: rtl/qr_byte_sel.sv
// Byte-address decode for the 128-bit state: one-hot byte enable plus the
// selected byte. The enable also steers result-register writes in the host.
import chacha_qr_pkg::*;

module qr_byte_sel (
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_BYTES-1:0]   byte_en,
    output logic [7:0]             byte_out
);

    always_comb begin
        byte_en       = '0;
        byte_en[addr] = 1'b1;
        byte_out      = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_en[i]) begin
                byte_out = byte_out | data[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/chacha_qr_host.sv
// Bus host that loads a ChaCha state into a byte-wide responder, strobes N
// quarter-round steps, reads the state back and presents it on state_out.
import chacha_qr_pkg::*;

module chacha_qr_host #(
    parameter int READ_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [127:0]           state_in,
    input  logic [ROUNDS_W-1:0]    rounds,
    output logic                   busy,
    output logic                   done,
    output logic [127:0]           state_out,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [7:0]             bus_wdata,
    output logic                   bus_wr_en,
    output logic                   bus_qr_en,
    input  logic [7:0]             bus_rdata
);

    localparam logic [1:0]        LAT_LAST  = 2'(READ_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);

    state_t                state;
    logic [127:0]          data_q;
    logic [127:0]          result_q;
    logic [127:0]          result_next;
    logic [ROUNDS_W-1:0]   rounds_q;
    logic [ROUNDS_W-1:0]   round_cnt;
    logic [ADDR_W-1:0]     addr_cnt;
    logic [1:0]            lat_cnt;
    logic [NUM_BYTES-1:0]  byte_en;
    logic [7:0]            sel_byte;

    qr_byte_sel u_sel (
        .data     (data_q),
        .addr     (addr_cnt),
        .byte_en  (byte_en),
        .byte_out (sel_byte)
    );

    assign bus_addr  = addr_cnt;
    assign bus_wdata = bus_wr_en ? sel_byte : 8'h00;

    always_comb begin
        result_next = result_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_en[i]) begin
                result_next[i*8 +: 8] = bus_rdata;
            end
        end
    end

    // state_out is loaded on the READ exit edge so it is already valid while done is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            result_q  <= '0;
            rounds_q  <= '0;
            round_cnt <= '0;
            addr_cnt  <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_out <= '0;
            bus_wr_en <= 1'b0;
            bus_qr_en <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_q    <= state_in;
                        rounds_q  <= rounds;
                        addr_cnt  <= '0;
                        bus_wr_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (addr_cnt == ADDR_LAST) begin
                        addr_cnt  <= '0;
                        lat_cnt   <= '0;
                        bus_wr_en <= 1'b0;
                        if (rounds_q != '0) begin
                            bus_qr_en <= 1'b1;
                            round_cnt <= ROUNDS_W'(1);
                            state     <= ST_ROUND;
                        end else begin
                            state <= ST_READ;
                        end
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                ST_ROUND: begin
                    if (round_cnt == rounds_q) begin
                        bus_qr_en <= 1'b0;
                        state     <= ST_READ;
                    end else begin
                        round_cnt <= round_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt  <= '0;
                        result_q <= result_next;
                        if (addr_cnt == ADDR_LAST) begin
                            addr_cnt  <= '0;
                            state_out <= result_next;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_qr_host.sv
// Runs three hosts (READ_LAT 0, 1, 3) side by side against byte-register
// responders and checks each result against a word-level quarter-round model.
module tb_chacha_qr_host;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] state_in = '0;
    logic [4:0]   rounds = '0;

    logic         busy_w[N];
    logic         done_w[N];
    logic         wr_w[N];
    logic         qr_w[N];
    logic [3:0]   addr_w[N];
    logic [7:0]   wdata_w[N];
    logic [7:0]   rdata_w[N];
    logic [127:0] sout_w[N];

    logic [7:0]   mem[N][16];
    logic [3:0]   apipe[N][3];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [127:0] cur_state = '0;

    int qr_cnt[N], qr_runs[N], done_cnt[N], done_lat[N], wr_cnt[N], overlap[N], wr_err[N], busy_err[N];
    logic prev_qr[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        chacha_qr_host #(.READ_LAT(lat_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .state_in  (state_in),
            .rounds    (rounds),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .state_out (sout_w[g]),
            .bus_addr  (addr_w[g]),
            .bus_wdata (wdata_w[g]),
            .bus_wr_en (wr_w[g]),
            .bus_qr_en (qr_w[g]),
            .bus_rdata (rdata_w[g])
        );
    end

    function automatic logic [127:0] qr(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        a = s[31:0]; b = s[63:32]; c = s[95:64]; d = s[127:96];
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] ref_result(input logic [127:0] s, input int n);
        logic [127:0] t = s;
        for (int k = 0; k < n; k++) t = qr(t);
        return t;
    endfunction

    function automatic logic [127:0] mem_word(input int i);
        logic [127:0] t;
        for (int b = 0; b < 16; b++) t[b*8 +: 8] = mem[i][b];
        return t;
    endfunction

    // Responder: byte file, one quarter round per qr_en, read data delayed by the instance latency
    always @(posedge clk) begin
        logic [127:0] t;
        for (int i = 0; i < N; i++) begin
            if (wr_w[i]) mem[i][addr_w[i]] <= wdata_w[i];
            if (qr_w[i]) begin
                t = qr(mem_word(i));
                for (int b = 0; b < 16; b++) mem[i][b] <= t[b*8 +: 8];
            end
            apipe[i][0] <= addr_w[i];
            apipe[i][1] <= apipe[i][0];
            apipe[i][2] <= apipe[i][1];
        end
    end

    always @* begin
        for (int i = 0; i < N; i++) begin
            if (lat_of(i) == 0) rdata_w[i] = mem[i][addr_w[i]];
            else                rdata_w[i] = mem[i][apipe[i][lat_of(i) - 1]];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_w[i] && qr_w[i]) overlap[i]++;
            if (qr_w[i]) begin
                qr_cnt[i]++;
                if (!prev_qr[i]) qr_runs[i]++;
            end
            prev_qr[i] = qr_w[i];
            if (wr_w[i]) begin
                if (addr_w[i] != wr_cnt[i][3:0] || wdata_w[i] !== cur_state[int'(addr_w[i])*8 +: 8]) wr_err[i]++;
                wr_cnt[i]++;
            end
            if (done_w[i]) begin
                done_cnt[i]++;
                done_lat[i] = cyc - start_cyc;
            end
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < N; i++) begin
            qr_cnt[i] = 0; qr_runs[i] = 0; done_cnt[i] = 0; done_lat[i] = 0;
            wr_cnt[i] = 0; overlap[i] = 0; wr_err[i] = 0; busy_err[i] = 0; prev_qr[i] = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("%s_lat%0d", tag, lat_of(i)),
                        {busy_w[i], done_w[i], wr_w[i], qr_w[i], addr_w[i], wdata_w[i], sout_w[i]}, '0);
    endtask

    task automatic pulse_start(input logic [127:0] s, input logic [4:0] r);
        clear_mon();
        cur_state = s;
        state_in  = s;
        rounds    = r;
        @(negedge clk) start = 1'b1;
        @(posedge clk) start_cyc = cyc;
        @(negedge clk) start = 1'b0;
    endtask

    // Run one transaction; p1/p2 are cycles (after start) at which extra starts are pulsed
    task automatic applyStimulus(input string tag, input logic [127:0] s, input logic [4:0] r,
                                 input logic [127:0] expv, input int p1, input int p2);
        int k, exp_lat, max_lat;
        bit all_done;
        max_lat = 16 + int'(r) + 16 * 4 + 1;
        pulse_start(s, r);
        k = 1;
        while (k <= 400) begin
            for (int i = 0; i < N; i++) begin
                exp_lat = 16 + int'(r) + 16 * (lat_of(i) + 1) + 1;
                if (k < exp_lat && !busy_w[i]) busy_err[i]++;
            end
            start = (k == p1 || k == p2);
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (done_cnt[i] == 0) all_done = 1'b0;
            if (all_done && k >= max_lat + 8) break;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checkOutput({tag, "_timeout"}, 160'(k > 400), '0);
        for (int i = 0; i < N; i++) begin
            string p = $sformatf("%s_lat%0d", tag, lat_of(i));
            exp_lat = 16 + int'(r) + 16 * (lat_of(i) + 1) + 1;
            checkOutput({p, "_state_out"}, sout_w[i], expv);
            checkOutput({p, "_done_cycle"}, done_lat[i], exp_lat);
            checkOutput({p, "_done_count"}, done_cnt[i], 1);
            checkOutput({p, "_qr_cycles"}, qr_cnt[i], int'(r));
            checkOutput({p, "_qr_runs"}, qr_runs[i], (r == 0) ? 1'b0 : 1'b1);
            checkOutput({p, "_wr_qr_overlap"}, overlap[i], 0);
            checkOutput({p, "_wr_cycles"}, wr_cnt[i], 16);
            checkOutput({p, "_wr_addr_data"}, wr_err[i], 0);
            checkOutput({p, "_busy"}, busy_err[i], 0);
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] st;
        logic [4:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [127:0] rs;

        vecs[0] = '{"rfc", {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111}, 5'd1,
                    {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4}};
        rs = {$urandom, $urandom, $urandom, $urandom};
        vecs[1] = '{"loopback", rs, 5'd0, rs};
        rs = {$urandom, $urandom, $urandom, $urandom};
        vecs[2] = '{"max_rounds", rs, 5'd31, ref_result(rs, 31)};
        for (int v = 3; v < 6; v++) begin
            logic [4:0] rr;
            rs = {$urandom, $urandom, $urandom, $urandom};
            rr = 5'($urandom_range(1, 30));
            vecs[v] = '{$sformatf("rand%0d", v), rs, rr, ref_result(rs, int'(rr))};
        end

        #1 checkReset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++)
            applyStimulus(vecs[v].name, vecs[v].st, vecs[v].rnd, vecs[v].exp, 0, 0);

        rs = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus("busy_start", rs, 5'd2, ref_result(rs, 2), 5, 30);

        rs = {$urandom, $urandom, $urandom, $urandom};
        pulse_start(rs, 5'd10);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkReset("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("mid_reset_no_done_lat%0d", lat_of(i)), done_cnt[i], 0);

        applyStimulus("after_reset", vecs[0].st, vecs[0].rnd, vecs[0].exp, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/chacha_qr_host.md
CHACHA_QR_HOST -- requirements
Module: chacha_qr_host

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, giving the bus read latency in cycles from bus_addr change to valid bus_rdata (range 0..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL change only on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a transaction.
REQ-005 SHALL have port state_in, input, 128, the initial words: a=[31:0], b=[63:32], c=[95:64], d=[127:96].
REQ-006 SHALL have port rounds, input, 5, the number of quarter-round steps to request (0..31).
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when state_out is valid.
REQ-009 SHALL have port state_out, output, 128, the result words, in the same packing as state_in.
REQ-010 SHALL have port bus_addr, output, 4, the responder address: [3:2] selects word a/b/c/d, [1:0] selects byte, little-endian.
REQ-011 SHALL have port bus_wdata, output, 8, the byte to write.
REQ-012 SHALL have port bus_wr_en, output, 1, the byte write strobe.
REQ-013 SHALL have port bus_qr_en, output, 1, the quarter-round step strobe.
REQ-014 SHALL have port bus_rdata, input, 8, the byte returned by the responder for bus_addr.

Function
REQ-015 SHALL implement the FSM IDLE -> WRITE -> ROUND -> READ -> FIN -> IDLE.
REQ-016 IDLE: start=1 SHALL latch state_in and rounds and enter WRITE; start SHALL be ignored in every other state.
REQ-017 WRITE: SHALL take 16 cycles with bus_wr_en=1 and bus_addr=0..15 ascending; bus_wdata SHALL be byte addr of the latched state; after addr 15 it SHALL go to ROUND.
REQ-018 ROUND: SHALL hold bus_qr_en=1 and bus_wr_en=0 for exactly the latched rounds cycles; rounds=0 SHALL skip ROUND entirely, with no qr_en pulse.
REQ-019 bus_wr_en and bus_qr_en SHALL never be high in the same cycle.
REQ-020 READ: bus_addr SHALL step 0..15, each held READ_LAT+1 cycles; bus_rdata SHALL be sampled in the last cycle of each hold into byte addr of the result register.
REQ-021 FIN: SHALL last one cycle, copy the result register to state_out, pulse done=1 and drop busy, then return to IDLE.
REQ-022 A transaction SHALL take 16 + rounds + 16*(READ_LAT+1) + 1 cycles from the cycle after start to done inclusive.
REQ-023 state_out SHALL hold its value until the next FIN.
REQ-024 The address and round counters SHALL be separate (4-bit and 5-bit); the address counter SHALL wrap 15 -> 0 only on a state exit.
REQ-025 In IDLE, bus_wr_en=0, bus_qr_en=0, bus_addr=0 and bus_wdata=0.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, bus_wr_en=0, bus_qr_en=0, bus_addr=0, bus_wdata=0, state_out=0, and clear all counters and latches.
REQ-027 rst asserted mid-transaction SHALL abort it with no done pulse; the next start after release SHALL run a full transaction.

Structure
REQ-028 The package chacha_qr_pkg SHALL hold the FSM state typedef, the address field widths, and the constants NUM_BYTES=16 and ROUNDS_W=5.
REQ-029 One sub-module, qr_byte_sel, SHALL provide the combinational 128-bit-to-byte select used for bus_wdata; the result register write SHALL use the same address decode.

Verification
REQ-030 The bench SHALL connect a behavioural responder model (byte register file plus one ChaCha quarter round per qr_en) with configurable read latency.
REQ-031 Scenario, RFC 7539 2.1.1 vector: a=11111111 b=01020304 c=9b8d6f43 d=01234567, rounds=1 -> state_out a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb, done at cycle 50 with READ_LAT=1.
REQ-032 Scenario, loopback: rounds=0, random state_in -> state_out == state_in, zero qr_en pulses, done at cycle 49.
REQ-033 Scenario, maximum rounds: rounds=31 -> exactly 31 consecutive qr_en cycles, and the result matches 31 model iterations.
REQ-034 Scenario, busy start: start pulsed during WRITE and again during READ -> ignored; exactly one done is seen.
REQ-035 Scenario, reset mid-operation: rst during ROUND -> outputs reach their reset values without waiting for a clock edge, no done is seen, and a following start gives the correct result.
REQ-036 Scenario, latency sweep: READ_LAT=0 and READ_LAT=3 with the REQ-031 vector -> the same state_out, done at cycles 34 and 82.
